// File: rtl/down_counter_ctrl_pkg.sv
// down_counter_ctrl_pkg
// Shared definitions for the loadable down-counter controller and its
// datapath: controller state encoding and the default counter width.
package down_counter_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // 2'b11 is deliberately unused; the controller treats it as illegal
    // and recovers to IDLE with the count cleared.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/down_counter_nbit.sv
// down_counter_nbit
// Datapath register for the down-counter: a WIDTH-bit register that can be
// cleared, loaded or decremented.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, clears out
//   ld     : load data into out
//   dec    : decrement out by one
//   clr    : synchronous clear of out
//   data   : load value
//   out    : current register value
//
// Priority: reset/clr > ld > dec.
module down_counter_nbit
    import down_counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             dec,
    input  logic             clr,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            out <= '0;
        end else if (ld) begin
            out <= data;
        end else if (dec && (out != '0)) begin
            // The zero guard keeps the register from wrapping even if a
            // decrement request ever arrives at zero.
            out <= out - WIDTH'(1);
        end
    end

endmodule

// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl
// Loadable down-counter with a small controller. A start strobe in IDLE
// loads a value; qualified dec pulses in COUNT count it down to zero, after
// which a single DONE cycle pulses done. With auto_reload high in DONE the
// count restarts from the latched load value.
//
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset
//   start       : begin a count sequence (accepted only in IDLE)
//   data        : load value, sampled on the accepting cycle
//   dec         : decrement enable, effective only in COUNT
//   clear       : synchronous abort to IDLE, count cleared, reload kept
//   auto_reload : sampled in DONE; restart from the latched value
//   count       : current counter value
//   busy        : high in COUNT and DONE
//   zero        : count == 0
//   done        : one-cycle pulse, high only in DONE
//   state_dbg   : controller state register, for observation
//   reload_dbg  : latched reload value, for observation
//
// Handshake: start behaves as a valid strobe whose implicit ready is
// (state == IDLE); a start seen in any other state is dropped, not queued.
// dec is a per-cycle enable with no back-pressure.
module down_counter_ctrl
    import down_counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             dec,
    input  logic             clear,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero,
    output logic             done,
    output logic [1:0]       state_dbg,
    output logic [WIDTH-1:0] reload_dbg
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] reload_q;
    logic             reload_ld;

    logic             dp_ld;
    logic             dp_dec;
    logic             dp_clr;
    logic [WIDTH-1:0] dp_data;

    // State and reload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= '0;
        end else if (reload_ld) begin
            reload_q <= data;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        reload_ld = 1'b0;
        dp_ld     = 1'b0;
        dp_dec    = 1'b0;
        dp_clr    = 1'b0;
        dp_data   = data;

        if (clear) begin
            state_d = IDLE;
            dp_clr  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dp_ld     = 1'b1;
                        dp_data   = data;
                        reload_ld = 1'b1;
                        // A zero load skips COUNT entirely so done still
                        // pulses exactly once.
                        state_d   = (data != '0) ? COUNT : DONE;
                    end
                end
                COUNT: begin
                    if (dec) begin
                        dp_dec = 1'b1;
                        if (count == WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (auto_reload && (reload_q != '0)) begin
                        dp_ld   = 1'b1;
                        dp_data = reload_q;
                        state_d = COUNT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dp_clr  = 1'b1;
                end
            endcase
        end
    end

    down_counter_nbit #(
        .WIDTH (WIDTH)
    ) u_nbit (
        .clk   (clk),
        .reset (reset),
        .ld    (dp_ld),
        .dec   (dp_dec),
        .clr   (dp_clr),
        .data  (dp_data),
        .out   (count)
    );

    assign busy       = (state_q == COUNT) || (state_q == DONE);
    assign done       = (state_q == DONE);
    assign zero       = (count == '0);
    assign state_dbg  = state_q;
    assign reload_dbg = reload_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
module tb_down_counter_ctrl;

  localparam int W = 4;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_COUNT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] data;
  logic         dec;
  logic         clear;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         busy;
  logic         zero;
  logic         done;
  logic [1:0]   state_dbg;
  logic [W-1:0] reload_dbg;

  always #5 clk = ~clk;

  down_counter_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data        (data),
    .dec         (dec),
    .clear       (clear),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .zero        (zero),
    .done        (done),
    .state_dbg   (state_dbg),
    .reload_dbg  (reload_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic s, input logic [W-1:0] d,
                       input logic dc, input logic c, input logic ar);
    reset = r; start = s; data = d; dec = dc; clear = c; auto_reload = ar;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic         st;
    logic [W-1:0] dat;
    logic         dc;
    logic         clr;
    logic         ar;
    logic [W-1:0] e_cnt;
    logic         e_busy;
    logic         e_zero;
    logic         e_done;
    logic [1:0]   e_state;
    logic [W-1:0] e_reload;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic st, input int dat,
                              input logic dc, input logic clr, input logic ar,
                              input int cnt, input logic b, input logic z,
                              input logic dn, input logic [1:0] s, input int rl);
    vec_t v;
    v.rst = rst; v.st = st; v.dat = W'(dat); v.dc = dc; v.clr = clr; v.ar = ar;
    v.e_cnt = W'(cnt); v.e_busy = b; v.e_zero = z; v.e_done = dn;
    v.e_state = s; v.e_reload = W'(rl);
    return v;
  endfunction

  int n_val;
  int exp_cnt;
  int eff;
  int cyc;
  bit seen;

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    //                rst st dat dc clr ar   cnt b  z  dn  state    reload
    // reset, then 3 with dec held high (dec in IDLE ignored)
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 1, 0, S_IDLE,  0));
    vecs.push_back(mk(0, 1, 3, 1, 0, 0,   3, 1, 0, 0, S_COUNT, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   2, 1, 0, 0, S_COUNT, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   1, 1, 0, 0, S_COUNT, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, S_DONE,  3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, S_IDLE,  3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, S_IDLE,  3));
    // zero-length sequence
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 1, 1, 1, S_DONE,  0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, S_IDLE,  0));
    // clear at count=4 of 7: no done, reload kept
    vecs.push_back(mk(0, 1, 7, 0, 0, 0,   7, 1, 0, 0, S_COUNT, 7));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   6, 1, 0, 0, S_COUNT, 7));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   5, 1, 0, 0, S_COUNT, 7));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   4, 1, 0, 0, S_COUNT, 7));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 0, S_IDLE,  7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, S_IDLE,  7));
    // start ignored in COUNT, then reset mid-count clears reload
    vecs.push_back(mk(0, 1, 9, 0, 0, 0,   9, 1, 0, 0, S_COUNT, 9));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0,   9, 1, 0, 0, S_COUNT, 9));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,   8, 1, 0, 0, S_COUNT, 9));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,   0, 0, 1, 0, S_IDLE,  0));
    // auto-reload with 2, dec in DONE ignored, then drop auto_reload
    vecs.push_back(mk(0, 1, 2, 1, 0, 1,   2, 1, 0, 0, S_COUNT, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1,   1, 1, 0, 0, S_COUNT, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1,   0, 1, 1, 1, S_DONE,  2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1,   2, 1, 0, 0, S_COUNT, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1,   1, 1, 0, 0, S_COUNT, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, S_DONE,  2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, S_IDLE,  2));
    // clear beats start in IDLE
    vecs.push_back(mk(0, 1, 5, 0, 1, 0,   0, 0, 1, 0, S_IDLE,  2));
    // auto_reload with reload=0 returns to IDLE
    vecs.push_back(mk(0, 1, 0, 0, 0, 1,   0, 1, 1, 1, S_DONE,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, S_IDLE,  0));
    // start and dec in DONE ignored
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   1, 1, 0, 0, S_COUNT, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, S_DONE,  1));
    vecs.push_back(mk(0, 1, 6, 1, 0, 0,   0, 0, 1, 0, S_IDLE,  1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].dat, vecs[i].dc, vecs[i].clr, vecs[i].ar);
      step();
      check($sformatf("v%0d count", i),  int'(count),      int'(vecs[i].e_cnt));
      check($sformatf("v%0d busy", i),   int'(busy),       int'(vecs[i].e_busy));
      check($sformatf("v%0d zero", i),   int'(zero),       int'(vecs[i].e_zero));
      check($sformatf("v%0d done", i),   int'(done),       int'(vecs[i].e_done));
      check($sformatf("v%0d state", i),  int'(state_dbg),  int'(vecs[i].e_state));
      check($sformatf("v%0d reload", i), int'(reload_dbg), int'(vecs[i].e_reload));
    end

    // ---------------- sequence A: data=5, dec toggling ----------------
    drive(1'b0, 1'b1, W'(5), 1'b0, 1'b0, 1'b0);
    step();
    check("seqA accept count", int'(count), 5);
    exp_cnt = 5;
    eff = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, '0, (i % 2) == 0, 1'b0, 1'b0);
      step();
      if (dec && exp_cnt > 0) begin
        exp_cnt--;
        eff++;
      end
      if (exp_cnt > 0) begin
        check($sformatf("seqA c%0d count", i), int'(count), exp_cnt);
        check($sformatf("seqA c%0d done", i), int'(done), 0);
      end else begin
        check("seqA done", int'(done), 1);
        check("seqA final count", int'(count), 0);
        check("seqA effective decs", eff, 5);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("seqA done timeout", 0, 1);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step();
    check("seqA back to idle", int'(state_dbg), int'(S_IDLE));
    check("seqA done low", int'(done), 0);

    // ---------------- sequence B: random N, dec held high ----------------
    n_val = $urandom_range(1, 15);
    drive(1'b0, 1'b1, W'(n_val), 1'b1, 1'b0, 1'b0);
    step();
    cyc = 1;
    seen = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (int'(count) > n_val) check("seqB count above load", int'(count), n_val);
      step();
      if (state_dbg == S_COUNT) begin
        cyc++;
      end else begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("seqB done timeout", 0, 1);
    check("seqB cycles in COUNT", cyc, n_val);
    check("seqB done pulse", int'(done), 1);
    check("seqB busy in DONE", int'(busy), 1);
    step();
    check("seqB done one cycle", int'(done), 0);
    check("seqB idle busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/down_counter_ctrl.md
Name: down_counter_ctrl

Overview:
Loadable down-counter with a small controller. It is the decrementing counterpart of the team's loadable up-counter. It accepts a start strobe with a load value, then counts down on qualified decrement pulses until it reaches zero, and signals completion with a one-cycle done pulse. An optional auto-reload mode restarts the count from the latched value. It serves as the loop/iteration timer in the controller/datapath pairs of this design.

Parameters:
WIDTH, 4, bit width of load value and count.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  reset, synchronous, active-high
start  input  1  begin a count sequence; sampled only in IDLE
data  input  WIDTH  load value, sampled on the cycle start is accepted
dec  input  1  decrement enable; effective only in COUNT
clear  input  1  synchronous abort to IDLE
auto_reload  input  1  sampled in DONE; 1 means restart from the latched value
count  output  WIDTH  current counter value
busy  output  1  high in COUNT and DONE
zero  output  1  combinational, count == 0
done  output  1  one-cycle pulse, high only in DONE

Behaviour:
- Reset: state=IDLE, count=0, reload register=0. Therefore busy=0, done=0, zero=1.
- Priority at each edge: reset > clear > state-specific action.
- clear: state goes to IDLE and count goes to 0, from any state. The reload register is kept.
- IDLE:
  - start=1 and data!=0: count<=data, reload<=data, next state COUNT.
  - start=1 and data==0: count<=0, reload<=0, next state DONE. This is a zero-length sequence; done pulses on the following cycle.
  - start=0: hold.
- COUNT:
  - dec=1 and count>1: count<=count-1.
  - dec=1 and count==1: count<=0, next state DONE.
  - dec=0: hold; no timeout.
  - start is ignored.
- DONE (exactly one cycle):
  - done=1.
  - auto_reload=1 and reload!=0: count<=reload, next state COUNT.
  - Otherwise: next state IDLE, count stays 0.
  - dec and start are ignored in this state.
- No underflow: count never wraps below 0. dec in IDLE or DONE is ignored.
- Latency:
  - start to first possible decrement: 1 cycle (dec on the cycle after acceptance is effective).
  - Last dec to done: done is high in the cycle immediately after the edge that set count to 0.
- A value N≥1 with dec held high gives N cycles in COUNT, then 1 DONE cycle.
- Width rule: arithmetic is modulo 2^WIDTH, but the zero guard makes wrap unreachable. data is unsigned.
- State encoding: 2 bits, IDLE=00, COUNT=01, DONE=10. 11 is illegal and recovers to IDLE with count=0.

Decomposition:
- Shared package: state encoding constants (IDLE, COUNT, DONE) and the default WIDTH.
- Natural split: FSM controller in down_counter_ctrl, plus one datapath sub-module down_counter_nbit.
  - Ports of down_counter_nbit: clk, reset, ld, dec, clr, data, out.
  - ld has priority over dec. clr has priority over both.
  - The reload register sits in the controller.

Test Plan:
- Reset, then start=1, data=3, dec held high: count 3→2→1→0 on consecutive cycles; done=1 exactly one cycle after count reaches 0; busy=1 from acceptance through DONE; then IDLE.
- start with data=5, dec toggling 1,0,1,0…: count changes only on dec=1 cycles; done appears after the 5th effective dec.
- start with data=0: next cycle done=1, count=0, busy=1; following cycle IDLE, busy=0.
- data=2, auto_reload=1, dec high: sequence 2,1,0(done),2,1,0(done)… repeats. Deassert auto_reload: after the next done, return to IDLE.
- Mid-count (count=4 of 7): assert clear → next cycle IDLE, count=0, no done pulse. Repeat using reset: same result, and the reload register is 0.
- start pulses during COUNT and dec pulses in IDLE/DONE: no effect on count or state. Checker asserts that count never exceeds the loaded value and never wraps.
